// File: rtl/imm_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imm_encoder                                                     |
// | Purpose  : Two-stage RV32I I/S/B/J instruction assembler with range check  |
// |            and word-aligned write-address generation.                      |
// | Option   : IMMENC_ERRCNT_EN adds a saturating err_count output.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module imm_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
`ifdef IMMENC_ERRCNT_EN
  ,output logic [15:0]      err_count
`endif
);

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic              r_s1_valid;
  logic [31:0]       r_s1_instr;
  logic              r_s1_err;
  logic              r_s2_valid;
  logic [31:0]       r_s2_instr;
  logic              r_s2_err;
  logic [ADDR_W-1:0] r_s2_addr;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_clr_pend;

  logic [31:0]       w_packed;
  logic              w_ok;
  logic              w_s1_adv;
  logic              w_accept;
  logic              w_hs;
  logic [ADDR_W-1:0] w_cnt_next;

  always_comb begin
    w_packed = '0;
    w_ok     = 1'b1;
    case (fmt)
      2'b00: begin
        w_packed = {imm[11:0], rs1, funct3, rd, opcode};
        w_ok     = (&imm[31:11]) || (~|imm[31:11]);
      end
      2'b01: begin
        w_packed = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_ok     = (&imm[31:11]) || (~|imm[31:11]);
      end
      2'b10: begin
        w_packed = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_ok     = ((&imm[31:12]) || (~|imm[31:12])) && !imm[0];
      end
      default: begin
        w_packed = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_ok     = ((&imm[31:20]) || (~|imm[31:20])) && !imm[0];
      end
    endcase
  end

  assign w_s1_adv = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s1_adv;
  assign w_accept = in_valid && in_ready;
  assign w_hs     = r_s2_valid && out_ready;

  // r_cnt holds the address of the beat in stage 2, or of the next beat to
  // arrive there. A clear while a beat is parked must not be undone by that
  // beat's later handshake, hence r_clr_pend.
  assign w_cnt_next = addr_clr ? BASE_ADDR :
                      (w_hs && !r_clr_pend) ? r_cnt + ADDR_W'(4) : r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_instr <= '0;
      r_s1_err   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
      r_s2_addr  <= BASE_ADDR;
      r_cnt      <= BASE_ADDR;
      r_clr_pend <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_instr <= w_ok ? w_packed : c_nop;
        r_s1_err   <= !w_ok;
      end
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= r_s1_instr;
          r_s2_err   <= r_s1_err;
          r_s2_addr  <= w_cnt_next;
        end
      end
      r_cnt <= w_cnt_next;
      if (addr_clr) begin
        r_clr_pend <= r_s2_valid && !out_ready;
      end else if (w_hs) begin
        r_clr_pend <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_instr = r_s2_instr;
  assign out_addr  = r_s2_addr;
  assign out_err   = r_s2_err;

`ifdef IMMENC_ERRCNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (addr_clr) begin
      r_err_count <= '0;
    end else if (w_hs && r_s2_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire
